// File: rtl/fp_exception_tracker_if.sv
// Operand-issue / result bus between the FPU front end and the exception tracker.
// The master issues operand pairs and consumes bypass results; the slave is the tracker.
interface fp_exception_tracker_if #(
    parameter int EXP_W = 4,
    parameter int MAN_W = 3,
    parameter int CNT_W = 8
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [W-1:0]     in0;
    logic [W-1:0]     in1;
    logic             out_valid;
    logic             out_ready;
    logic             exc;
    logic [3:0]       flags;
    logic [W-1:0]     result;
    logic [3:0]       sticky;
    logic [CNT_W-1:0] exc_count;
    logic             clr;

    modport master (
        output in_valid, op, in0, in1, out_ready, clr,
        input  in_ready, out_valid, exc, flags, result, sticky, exc_count
    );

    modport slave (
        input  in_valid, op, in0, in1, out_ready, clr,
        output in_ready, out_valid, exc, flags, result, sticky, exc_count
    );
endinterface

// File: rtl/fp_exception_tracker.sv
// Registered FP exception classifier: flags special-operand cases for add/sub/mul/div,
// produces the bypass NaN/Inf result, and keeps sticky flags plus a saturating counter.
module fp_exception_tracker #(
    parameter int EXP_W = 4,
    parameter int MAN_W = 3,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fp_exception_tracker_if.slave bus
);
    localparam int W = 1 + EXP_W + MAN_W;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, MAN_W'(1) << (MAN_W - 1)};

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    function automatic logic exp_ones(input logic [W-1:0] x);
        return &x[MAN_W +: EXP_W];
    endfunction

    function automatic logic is_nan(input logic [W-1:0] x);
        return exp_ones(x) && (|x[MAN_W-1:0]);
    endfunction

    function automatic logic is_inf(input logic [W-1:0] x);
        return exp_ones(x) && !(|x[MAN_W-1:0]);
    endfunction

    function automatic logic is_zero(input logic [W-1:0] x);
        return !(|x[W-2:0]);
    endfunction

    function automatic logic [W-1:0] inf_val(input logic s);
        return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic             out_valid_q;
    logic [3:0]       flags_q;
    logic [W-1:0]     result_q;
    logic [3:0]       sticky_q,  sticky_d;
    logic [CNT_W-1:0] count_q,   count_d;

    logic [3:0]       flags_n;
    logic [W-1:0]     result_n;
    logic             accept;

    logic sa, sb, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, fin_nz_a;
    logic invalid;

    assign sa       = bus.in0[W-1];
    assign sb       = bus.in1[W-1];
    assign nan_a    = is_nan(bus.in0);
    assign nan_b    = is_nan(bus.in1);
    assign inf_a    = is_inf(bus.in0);
    assign inf_b    = is_inf(bus.in1);
    assign zero_a   = is_zero(bus.in0);
    assign zero_b   = is_zero(bus.in1);
    assign fin_nz_a = !exp_ones(bus.in0) && !zero_a;

    always_comb begin
        invalid = 1'b0;
        unique case (bus.op)
            OP_ADD: invalid = inf_a && inf_b && (sa != sb);
            OP_SUB: invalid = inf_a && inf_b && (sa == sb);
            OP_MUL: invalid = (zero_a && inf_b) || (inf_a && zero_b);
            OP_DIV: invalid = (zero_a && zero_b) || (inf_a && inf_b);
            default: invalid = 1'b0;
        endcase
    end

    // Priority chain: NaN input, invalid, divide-by-zero, then plain infinity.
    // A finite dividend over an infinite divisor is left to the normal datapath.
    always_comb begin
        flags_n  = '0;
        result_n = '0;
        if (nan_a || nan_b) begin
            flags_n[2] = 1'b1;
            result_n   = QNAN;
        end else if (invalid) begin
            flags_n[0] = 1'b1;
            result_n   = QNAN;
        end else if ((bus.op == OP_DIV) && fin_nz_a && zero_b) begin
            flags_n[1] = 1'b1;
            result_n   = inf_val(sa ^ sb);
        end else if (inf_a || (inf_b && (bus.op != OP_DIV))) begin
            flags_n[3] = 1'b1;
            unique case (bus.op)
                OP_ADD:  result_n = inf_val(inf_a ? sa : sb);
                OP_SUB:  result_n = inf_val(inf_a ? sa : ~sb);
                default: result_n = inf_val(sa ^ sb);
            endcase
        end
    end

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // clr wipes the accumulated state first so a simultaneous op starts a fresh history.
    always_comb begin
        sticky_d = bus.clr ? '0 : sticky_q;
        count_d  = bus.clr ? '0 : count_q;
        if (accept) begin
            sticky_d = sticky_d | flags_n;
            if (|flags_n) begin
                count_d = sat_inc(count_d);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            flags_q     <= '0;
            result_q    <= '0;
            sticky_q    <= '0;
            count_q     <= '0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                flags_q     <= flags_n;
                result_q    <= result_n;
            end else if (bus.in_ready) begin
                out_valid_q <= 1'b0;
                flags_q     <= '0;
                result_q    <= '0;
            end
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.flags     = flags_q;
    assign bus.exc       = |flags_q;
    assign bus.result    = result_q;
    assign bus.sticky    = sticky_q;
    assign bus.exc_count = count_q;
endmodule

// File: tb/tb_fp_exception_tracker.sv
// Bench for fp_exception_tracker: vector table through a scoreboard queue, plus
// backpressure, sticky/counter, saturation (CNT_W=2) and asynchronous reset sequences.
module tb_fp_exception_tracker;
    localparam int EXP_W = 4;
    localparam int MAN_W = 3;
    localparam int NV    = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_exception_tracker_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(8)) ifc ();
    fp_exception_tracker_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(2)) ifc2 ();

    fp_exception_tracker #(.EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(ifc)
    );
    fp_exception_tracker #(.EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .bus(ifc2)
    );

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] flags;
        logic [7:0] res;
    } vec_t;

    typedef struct packed {
        logic [3:0] flags;
        logic [7:0] res;
    } exp_t;

    vec_t vecs [NV];
    exp_t sbq [$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    // Scoreboard side: every transfer pops exactly one expected record.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && ifc.out_valid && ifc.out_ready) begin
            if (sbq.size() == 0) begin
                check("unexpected_output", sbq.size(), 1);
            end else begin
                e = sbq.pop_front();
                check("flags",  ifc.flags,  e.flags);
                check("result", ifc.result, e.res);
                check("exc",    ifc.exc,    |e.flags);
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic drive_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic [3:0] fl, input logic [7:0] res, input logic c);
        int budget = 0;
        ifc.in_valid = 1'b1;
        ifc.op       = op;
        ifc.in0      = a;
        ifc.in1      = b;
        ifc.clr      = c;
        @(negedge clk);
        while (!ifc.in_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!ifc.in_ready) begin
            check("accept_timeout", ifc.in_ready, 1);
            @(posedge clk);
            #1;
        end else begin
            @(posedge clk);
            sbq.push_back({fl, res});
            #1;
        end
        ifc.in_valid = 1'b0;
        ifc.clr      = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        logic [3:0] sticky_exp;
        int         cnt_exp;

        vecs[0]  = '{2'd0, 8'h79, 8'h00, 4'b0100, 8'h7C};
        vecs[1]  = '{2'd1, 8'h79, 8'h00, 4'b0100, 8'h7C};
        vecs[2]  = '{2'd0, 8'h78, 8'hF8, 4'b0001, 8'h7C};
        vecs[3]  = '{2'd1, 8'h78, 8'h78, 4'b0001, 8'h7C};
        vecs[4]  = '{2'd0, 8'h78, 8'h78, 4'b1000, 8'h78};
        vecs[5]  = '{2'd0, 8'h38, 8'h38, 4'b0000, 8'h00};
        vecs[6]  = '{2'd3, 8'h38, 8'h00, 4'b0010, 8'h78};
        vecs[7]  = '{2'd3, 8'hB8, 8'h00, 4'b0010, 8'hF8};
        vecs[8]  = '{2'd3, 8'h00, 8'h00, 4'b0001, 8'h7C};
        vecs[9]  = '{2'd2, 8'h00, 8'hF8, 4'b0001, 8'h7C};
        vecs[10] = '{2'd3, 8'h38, 8'h78, 4'b0000, 8'h00};
        vecs[11] = '{2'd1, 8'h38, 8'hF8, 4'b1000, 8'h78};
        vecs[12] = '{2'd2, 8'hB8, 8'h78, 4'b1000, 8'hF8};
        vecs[13] = '{2'd3, 8'hF8, 8'h38, 4'b1000, 8'hF8};
        vecs[14] = '{2'd0, 8'h00, 8'hFF, 4'b0100, 8'h7C};
        vecs[15] = '{2'd2, 8'hF8, 8'h00, 4'b0001, 8'h7C};
        vecs[16] = '{2'd3, 8'hF8, 8'h78, 4'b0001, 8'h7C};
        vecs[17] = '{2'd1, 8'hF8, 8'h78, 4'b1000, 8'hF8};
        vecs[18] = '{2'd0, 8'h01, 8'h80, 4'b0000, 8'h00};
        vecs[19] = '{2'd3, 8'h01, 8'h00, 4'b0010, 8'h78};

        ifc.in_valid = 0; ifc.op = 0; ifc.in0 = 0; ifc.in1 = 0; ifc.clr = 0; ifc.out_ready = 1;
        ifc2.in_valid = 0; ifc2.op = 0; ifc2.in0 = 0; ifc2.in1 = 0; ifc2.clr = 0; ifc2.out_ready = 1;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", ifc.out_valid, 0);
        check("rst_result",    ifc.result,    0);
        check("rst_sticky",    ifc.sticky,    0);
        check("rst_count",     ifc.exc_count, 0);
        check("rst_in_ready",  ifc.in_ready,  1);
        @(posedge clk); #1;

        // Back-to-back vector table
        sticky_exp = '0;
        cnt_exp    = 0;
        for (int i = 0; i < NV; i++) begin
            drive_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].flags, vecs[i].res, 1'b0);
            sticky_exp = sticky_exp | vecs[i].flags;
            if (vecs[i].flags != 0) cnt_exp++;
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_out_valid", ifc.out_valid, 0);
        check("idle_flags",     ifc.flags,     0);
        check("idle_result",    ifc.result,    0);
        check("table_sticky",   ifc.sticky,    sticky_exp);
        check("table_count",    ifc.exc_count, cnt_exp);
        @(posedge clk); #1;

        // clr alone
        ifc.clr = 1'b1;
        @(posedge clk); #1;
        ifc.clr = 1'b0;
        @(negedge clk);
        check("clr_sticky", ifc.sticky,    0);
        check("clr_count",  ifc.exc_count, 0);
        @(posedge clk); #1;

        // nan, div0, inf accumulate
        drive_op(2'd0, 8'h79, 8'h00, 4'b0100, 8'h7C, 1'b0);
        drive_op(2'd3, 8'h38, 8'h00, 4'b0010, 8'h78, 1'b0);
        drive_op(2'd0, 8'h78, 8'h78, 4'b1000, 8'h78, 1'b0);
        @(negedge clk);
        check("acc_sticky", ifc.sticky,    4'b1110);
        check("acc_count",  ifc.exc_count, 3);
        @(posedge clk); #1;

        // clr together with an invalid op
        drive_op(2'd1, 8'h78, 8'h78, 4'b0001, 8'h7C, 1'b1);
        @(negedge clk);
        check("clracc_sticky", ifc.sticky,    4'b0001);
        check("clracc_count",  ifc.exc_count, 1);
        @(posedge clk); #1;

        // Backpressure: A pending, B waiting for three stalled cycles
        ifc.out_ready = 1'b0;
        drive_op(2'd3, 8'hB8, 8'h00, 4'b0010, 8'hF8, 1'b0);
        ifc.in_valid = 1'b1; ifc.op = 2'd0; ifc.in0 = 8'h78; ifc.in1 = 8'hF8;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready",  ifc.in_ready,  0);
            check("bp_out_valid", ifc.out_valid, 1);
            check("bp_flags",     ifc.flags,     4'b0010);
            check("bp_result",    ifc.result,    8'hF8);
        end
        @(posedge clk); #1;
        ifc.out_ready = 1'b1;
        drive_op(2'd0, 8'h78, 8'hF8, 4'b0001, 8'h7C, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_drained",   sbq.size(),    0);
        check("bp_out_valid_end", ifc.out_valid, 0);
        check("bp_count",     ifc.exc_count, 3);
        @(posedge clk); #1;

        // Asynchronous reset while a result is valid and sticky is set
        drive_op(2'd0, 8'h79, 8'h00, 4'b0100, 8'h7C, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", ifc.out_valid, 0);
        check("arst_exc",       ifc.exc,       0);
        check("arst_flags",     ifc.flags,     0);
        check("arst_result",    ifc.result,    0);
        check("arst_sticky",    ifc.sticky,    0);
        check("arst_count",     ifc.exc_count, 0);
        sbq.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_op(2'd3, 8'h38, 8'h00, 4'b0010, 8'h78, 1'b0);
        @(negedge clk);
        check("post_rst_sticky", ifc.sticky,    4'b0010);
        check("post_rst_count",  ifc.exc_count, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("post_rst_drained", sbq.size(), 0);
        @(posedge clk); #1;

        // CNT_W=2 saturation
        for (int i = 0; i < 5; i++) begin
            ifc2.in_valid = 1'b1; ifc2.op = 2'd3; ifc2.in0 = 8'h38; ifc2.in1 = 8'h00;
            @(posedge clk); #1;
            @(negedge clk);
            check("sat_count", ifc2.exc_count, (i + 1 > 3) ? 3 : i + 1);
        end
        ifc2.in_valid = 1'b0;
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
